sram_cmd_seq: RTL and testbench
===============================

# sram_cmd_seq

Command sequencer sitting directly upstream of the mixed-signal SRAM top. Accepts word-level read/write commands over a valid/ready handshake and turns them into the SRAM's bit-serial load (serial_in + shift), write strobe (w_en), row address and read enable (r_en). Captures the SRAM's parallel read word and returns it over a valid/ready response channel.

## Interface
- ROWS, 16, number of SRAM rows; must match the SRAM instance
- COLS, 8, word width in bits; must match the SRAM instance
- RD_WAIT, 2, minimum cycles r_en is held before read capture (≥1)

- clk  in  1  single clock, all state on rising edge
- arst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_we  in  1  1 = write, 0 = read
- cmd_addr  in  $clog2(ROWS)  row index
- cmd_wdata  in  COLS  write data
- rsp_valid  out  1  read data available
- rsp_ready  in  1  consumer takes response
- rsp_rdata  out  COLS  read data
- wr_err  out  1  sticky write-verify mismatch flag
- sram_serial_in  out  1  serial data bit to SRAM
- sram_shift  out  1  SRAM shift-register enable
- sram_w_en  out  1  SRAM write/load strobe
- sram_r_en  out  1  SRAM read enable
- sram_addr  out  ROWS  row index, binary, zero-extended into low $clog2(ROWS) bits, upper bits 0
- sram_data_valid  in  1  SRAM read-valid
- sram_data_out  in  COLS  SRAM read word

## Operation
- States: IDLE, SHIFT, WRITE, READ, RESP, VERIFY (VERIFY only with macro).
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready latch we, addr, wdata; addr drives sram_addr (registered) until return to IDLE.
- Write: IDLE→SHIFT. SHIFT lasts exactly COLS cycles, sram_shift=1, sram_serial_in = wdata[COLS-1-k] on k-th shift cycle (MSB first; SIPO shifts toward MSB so first bit lands at bit COLS-1). Bit counter 0..COLS-1, wraps to 0 on exit. SHIFT→WRITE: sram_w_en=1 for one cycle, sram_shift=0. WRITE→IDLE (or VERIFY). No response for writes.
- Read: IDLE→READ. sram_r_en=1 throughout READ. Wait counter counts RD_WAIT cycles; on the first cycle with count≥RD_WAIT-1 and sram_data_valid=1, capture sram_data_out into rsp_rdata, go RESP. If data_valid stays low, remain in READ with r_en high.
- RESP: rsp_valid=1, rsp_rdata stable; on rsp_ready go IDLE. cmd_ready=0 while response pending.
- Outputs not named active in a state are 0.
- Reset: all outputs 0 (rsp_rdata 0, sram_addr 0, wr_err 0), state IDLE; in-flight command dropped, no partial w_en issued.

## Timing
- Command accepted at cycle T.
- Write: shifts T+1..T+COLS, sram_w_en at T+COLS+1, cmd_ready high again at T+COLS+2.
- Read (data_valid follows r_en): sram_r_en T+1..T+RD_WAIT, capture at end of T+RD_WAIT, rsp_valid from T+RD_WAIT+1; rsp_ready same cycle → cmd_ready at T+RD_WAIT+2.
- No back-to-back accept: one command in flight at a time.

## Configuration
- SRAM_SEQ_WR_VERIFY_EN defined: after WRITE, enter VERIFY: r_en high as in READ (same RD_WAIT/data_valid rule), compare captured word with latched wdata; mismatch sets wr_err (sticky until reset). No rsp_valid for verify. Write occupancy becomes COLS+1+RD_WAIT cycles.
- Undefined: VERIFY absent, WRITE→IDLE, wr_err tied 0.

## Test plan
- Reset mid-SHIFT (after 3 bits of 0xA5) → all outputs 0 next edge, no sram_w_en, cmd_ready=1 after release.
- Write addr 5, data 0xA5, COLS=8 → serial_in sequence 1,0,1,0,0,1,0,1 on 8 shift cycles, sram_addr=16'h0005, one-cycle w_en at T+9.
- Write 0x3C addr 15 then read addr 15 → rsp_rdata=0x3C, rsp_valid at T+RD_WAIT+1.
- Read with rsp_ready low 5 cycles → rsp_valid and rsp_rdata held, cmd_ready=0, cmd_valid ignored until handshake.
- Read with sram_data_valid forced low 4 extra cycles → r_en held, capture on first valid cycle.
- With SRAM_SEQ_WR_VERIFY_EN, model returns 0x00 after writing 0xFF → wr_err=1 and remains 1 across later good writes until arst_n.

Source files
------------

// File: rtl/sram_cmd_seq_if.sv
// Word-level command/response channel between a requester and sram_cmd_seq.
// Two valid/ready handshakes: command (requester -> sequencer) and read response.
interface sram_cmd_seq_if #(
    parameter int ROWS = 16,
    parameter int COLS = 8
);
    localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [COLS-1:0]   cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [COLS-1:0]   rsp_rdata;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_cmd_seq.sv
// Command sequencer for the bit-serial-load SRAM: word writes become MSB-first shifts plus a
// write strobe, reads hold r_en until the data is captured. Optional SRAM_SEQ_WR_VERIFY_EN read-back check.
module sram_cmd_seq #(
    parameter int ROWS    = 16,
    parameter int COLS    = 8,
    parameter int RD_WAIT = 2
) (
    input  logic            clk,
    input  logic            arst_n,
    sram_cmd_seq_if.slave   bus,
    output logic            wr_err,
    output logic            sram_serial_in,
    output logic            sram_shift,
    output logic            sram_w_en,
    output logic            sram_r_en,
    output logic [ROWS-1:0] sram_addr,
    input  logic            sram_data_valid,
    input  logic [COLS-1:0] sram_data_out
);
    localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BIT_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(COLS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_WAIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHIFT  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
`ifdef SRAM_SEQ_WR_VERIFY_EN
        ST_VERIFY = 3'd5,
`endif
        ST_RESP   = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [COLS-1:0]   wdata_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic [BIT_W-1:0]  bit_cnt_nxt_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;
    logic [COLS-1:0]   rdata_r;
    logic              rsp_valid_r;
    logic              cmd_ready_r;
    logic              shift_r;
    logic              serial_r;
    logic              w_en_r;
    logic              r_en_r;
    logic [ROWS-1:0]   sram_addr_r;

    logic              accept_s;
    logic              capture_s;
    logic              rd_done_s;
    logic              verify_bad_s;
    logic [ADDR_W-1:0] addr_src_s;
    logic [COLS-1:0]   wdata_src_s;
    logic [BIT_W-1:0]  bit_idx_s;
    logic [COLS-1:0]   rdata_nxt_s;
    logic              rsp_valid_nxt_s;
    logic              cmd_ready_nxt_s;
    logic              shift_nxt_s;
    logic              serial_nxt_s;
    logic              w_en_nxt_s;
    logic              r_en_nxt_s;
    logic [ROWS-1:0]   sram_addr_nxt_s;

    // Read data is usable once r_en has been held RD_WAIT cycles and the SRAM flags it valid.
    assign rd_done_s = (wait_cnt_r >= WAIT_LAST) && sram_data_valid;

    // Next-state and counter sequencing.
    always_comb begin
        state_nxt_s    = state_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        wait_cnt_nxt_s = wait_cnt_r;
        accept_s       = 1'b0;
        capture_s      = 1'b0;
        verify_bad_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_r) begin
                    accept_s       = 1'b1;
                    bit_cnt_nxt_s  = {BIT_W{1'b0}};
                    wait_cnt_nxt_s = {WAIT_W{1'b0}};
                    if (bus.cmd_we) begin
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bit_cnt_r == BIT_LAST) begin
                    state_nxt_s   = ST_WRITE;
                    bit_cnt_nxt_s = {BIT_W{1'b0}};
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                end
            end
            ST_WRITE: begin
`ifdef SRAM_SEQ_WR_VERIFY_EN
                state_nxt_s    = ST_VERIFY;
                wait_cnt_nxt_s = {WAIT_W{1'b0}};
`else
                state_nxt_s    = ST_IDLE;
`endif
            end
            ST_READ: begin
                if (rd_done_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_RESP;
                end else if (wait_cnt_r != WAIT_LAST) begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
`ifdef SRAM_SEQ_WR_VERIFY_EN
            ST_VERIFY: begin
                if (rd_done_s) begin
                    verify_bad_s = (sram_data_out != wdata_r);
                    state_nxt_s  = ST_IDLE;
                end else if (wait_cnt_r != WAIT_LAST) begin
                    wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r;
                end
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so every output is a flop.
    always_comb begin
        addr_src_s      = accept_s ? bus.cmd_addr : addr_r;
        wdata_src_s     = accept_s ? bus.cmd_wdata : wdata_r;
        bit_idx_s       = BIT_LAST - bit_cnt_nxt_s;
        shift_nxt_s     = (state_nxt_s == ST_SHIFT);
        w_en_nxt_s      = (state_nxt_s == ST_WRITE);
        rsp_valid_nxt_s = (state_nxt_s == ST_RESP);
        cmd_ready_nxt_s = (state_nxt_s == ST_IDLE);
`ifdef SRAM_SEQ_WR_VERIFY_EN
        r_en_nxt_s      = (state_nxt_s == ST_READ) || (state_nxt_s == ST_VERIFY);
`else
        r_en_nxt_s      = (state_nxt_s == ST_READ);
`endif
        if (shift_nxt_s) begin
            serial_nxt_s = wdata_src_s[bit_idx_s];
        end else begin
            serial_nxt_s = 1'b0;
        end
        if (state_nxt_s != ST_IDLE) begin
            sram_addr_nxt_s = ROWS'(addr_src_s);
        end else begin
            sram_addr_nxt_s = {ROWS{1'b0}};
        end
        // Captured word is only presented while the response is pending.
        if (capture_s) begin
            rdata_nxt_s = sram_data_out;
        end else if (rsp_valid_nxt_s) begin
            rdata_nxt_s = rdata_r;
        end else begin
            rdata_nxt_s = {COLS{1'b0}};
        end
    end

    // State, latched command and registered outputs.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r     <= ST_IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= {COLS{1'b0}};
            bit_cnt_r   <= {BIT_W{1'b0}};
            wait_cnt_r  <= {WAIT_W{1'b0}};
            rdata_r     <= {COLS{1'b0}};
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b0;
            shift_r     <= 1'b0;
            serial_r    <= 1'b0;
            w_en_r      <= 1'b0;
            r_en_r      <= 1'b0;
            sram_addr_r <= {ROWS{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            addr_r      <= addr_src_s;
            wdata_r     <= wdata_src_s;
            bit_cnt_r   <= bit_cnt_nxt_s;
            wait_cnt_r  <= wait_cnt_nxt_s;
            rdata_r     <= rdata_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            cmd_ready_r <= cmd_ready_nxt_s;
            shift_r     <= shift_nxt_s;
            serial_r    <= serial_nxt_s;
            w_en_r      <= w_en_nxt_s;
            r_en_r      <= r_en_nxt_s;
            sram_addr_r <= sram_addr_nxt_s;
        end
    end

`ifdef SRAM_SEQ_WR_VERIFY_EN
    logic wr_err_r;

    // Sticky read-back mismatch flag; only a hard reset clears it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_err_r <= 1'b0;
        end else if (verify_bad_s) begin
            wr_err_r <= 1'b1;
        end else begin
            wr_err_r <= wr_err_r;
        end
    end

    assign wr_err = wr_err_r;
`else
    assign wr_err = 1'b0;
`endif

    assign bus.cmd_ready  = cmd_ready_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_rdata  = rdata_r;
    assign sram_shift     = shift_r;
    assign sram_serial_in = serial_r;
    assign sram_w_en      = w_en_r;
    assign sram_r_en      = r_en_r;
    assign sram_addr      = sram_addr_r;
endmodule

// File: tb/tb_sram_cmd_seq.sv
// Scoreboard bench for sram_cmd_seq: directed commands push expectations, a negedge monitor
// checks write shifts/strobes and read responses against a behavioural SIPO SRAM model.
module tb_sram_cmd_seq;
    localparam int ROWS    = 16;
    localparam int COLS    = 8;
    localparam int RD_WAIT = 2;

    logic            clk = 1'b0;
    logic            arst_n;
    logic            wr_err;
    logic            sram_serial_in;
    logic            sram_shift;
    logic            sram_w_en;
    logic            sram_r_en;
    logic [ROWS-1:0] sram_addr;
    logic            sram_data_valid;
    logic [COLS-1:0] sram_data_out;

    sram_cmd_seq_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    sram_cmd_seq #(.ROWS(ROWS), .COLS(COLS), .RD_WAIT(RD_WAIT)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .bus             (bus),
        .wr_err          (wr_err),
        .sram_serial_in  (sram_serial_in),
        .sram_shift      (sram_shift),
        .sram_w_en       (sram_w_en),
        .sram_r_en       (sram_r_en),
        .sram_addr       (sram_addr),
        .sram_data_valid (sram_data_valid),
        .sram_data_out   (sram_data_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- SRAM model ----------------
    logic [7:0] mem [16];
    logic [7:0] sr = 8'h00;
    int         rcnt = 0;
    int         stall_n = 0;
    bit         corrupt = 1'b0;

    always @(posedge clk) begin
        if (sram_shift) sr <= {sr[6:0], sram_serial_in};
        if (sram_w_en) mem[sram_addr[3:0]] <= sr;
        rcnt <= sram_r_en ? rcnt + 1 : 0;
    end

    assign sram_data_valid = sram_r_en && (rcnt >= stall_n);
    assign sram_data_out   = corrupt ? 8'h00 : mem[sram_addr[3:0]];

    // ---------------- scoreboard ----------------
    typedef struct { logic [3:0] addr; logic [7:0] data; } wr_exp_t;
    typedef struct { logic [7:0] data; int lat; } rd_exp_t;
    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    int exp_wen = 0;
    int wen_cnt = 0;

    initial begin
        int      acc_cyc;
        int      ncol;
        int      ren_cnt;
        logic [7:0] col;
        logic [7:0] held;
        bit      prev_valid;
        bit      prev_hs;
        bit      prev_wen;
        wr_exp_t we;
        rd_exp_t re;
        acc_cyc = 0; ncol = 0; ren_cnt = 0; col = 8'h00; held = 8'h00;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_wen = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                ncol = 0; col = 8'h00; ren_cnt = 0;
                prev_valid = 1'b0; prev_hs = 1'b0; prev_wen = 1'b0;
            end else begin
                if (prev_hs) chk("ready_after_rsp", bus.cmd_ready, 1);
`ifndef SRAM_SEQ_WR_VERIFY_EN
                if (prev_wen) chk("ready_after_wen", bus.cmd_ready, 1);
`endif
                if (bus.cmd_valid && bus.cmd_ready) begin
                    acc_cyc = cyc; ncol = 0; ren_cnt = 0;
                end
                if (sram_r_en) ren_cnt++;
                if (sram_shift) begin
                    col = {col[6:0], sram_serial_in};
                    ncol++;
                end
                if (sram_w_en) begin
                    wen_cnt++;
                    if (wr_q.size() == 0) begin
                        chk("unexpected_wen", 1, 0);
                    end else begin
                        we = wr_q.pop_front();
                        chk("wr_serial_word", col, we.data);
                        chk("wr_shift_count", ncol, COLS);
                        chk("wr_addr", sram_addr, {12'h000, we.addr});
                        chk("wen_cycle", cyc - acc_cyc, COLS + 1);
                    end
                end
                if (bus.rsp_valid && !prev_valid) begin
                    if (rd_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                    end else begin
                        re = rd_q.pop_front();
                        chk("rsp_rdata", bus.rsp_rdata, re.data);
                        chk("rsp_latency", cyc - acc_cyc, re.lat);
                        chk("ren_cycles", ren_cnt, re.lat - 1);
                    end
                    held = bus.rsp_rdata;
                end
                if (bus.rsp_valid) begin
                    chk("rsp_rdata_stable", bus.rsp_rdata, held);
                    chk("busy_cmd_ready", bus.cmd_ready, 0);
                end
                prev_valid = bus.rsp_valid;
                prev_hs    = bus.rsp_valid && bus.rsp_ready;
                prev_wen   = sram_w_en;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready();
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
    endtask

    task automatic issue(bit we, logic [3:0] a, logic [7:0] d, int lat, bit expect_it);
        wait_ready();
        if (expect_it) begin
            if (we) begin
                wr_q.push_back('{a, d});
                exp_wen++;
            end else begin
                rd_q.push_back('{d, lat});
            end
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = we;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
        chk({tag, "_shift"}, sram_shift, 0);
        chk({tag, "_serial_in"}, sram_serial_in, 0);
        chk({tag, "_w_en"}, sram_w_en, 0);
        chk({tag, "_r_en"}, sram_r_en, 0);
        chk({tag, "_sram_addr"}, sram_addr, 0);
        chk({tag, "_wr_err"}, wr_err, 0);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        arst_n        = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_we    = 1'b0;
        bus.cmd_addr  = 4'h0;
        bus.cmd_wdata = 8'h00;
        bus.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        arst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_release", bus.cmd_ready, 1);

        // write A5 @5: serial 1,0,1,0,0,1,0,1 then w_en at T+9
        issue(1'b1, 4'd5, 8'hA5, 0, 1'b1);
        // write 3C @15, read it back
        issue(1'b1, 4'd15, 8'h3C, 0, 1'b1);
        issue(1'b0, 4'd15, 8'h3C, RD_WAIT + 1, 1'b1);

        // response back-pressure for 5 cycles with a competing command offered
        wait_ready();
        bus.rsp_ready = 1'b0;
        issue(1'b0, 4'd5, 8'hA5, RD_WAIT + 1, 1'b1);
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_valid_wait", bus.rsp_valid, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_we    = 1'b1;
        bus.cmd_addr  = 4'd0;
        bus.cmd_wdata = 8'hFF;
        repeat (5) @(posedge clk);
        #1 chk("rsp_valid_held", bus.rsp_valid, 1);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;

        // data_valid held low 4 cycles past the normal capture point
        wait_ready();
        stall_n = RD_WAIT - 1 + 4;
        issue(1'b0, 4'd15, 8'h3C, RD_WAIT + 5, 1'b1);
        wait_ready();
        stall_n = 0;

        // boundary addresses / data
        issue(1'b1, 4'd0, 8'h00, 0, 1'b1);
        issue(1'b1, 4'd1, 8'hFF, 0, 1'b1);
        issue(1'b0, 4'd0, 8'h00, RD_WAIT + 1, 1'b1);
        issue(1'b0, 4'd1, 8'hFF, RD_WAIT + 1, 1'b1);

        // reset in the middle of shifting A5 into row 7: no strobe, row 7 untouched
        issue(1'b1, 4'd7, 8'hA5, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2 arst_n = 1'b0;
        #1 check_all_zero("midshift");
        @(posedge clk); #1;
        arst_n = 1'b1;
        wait_ready();
        issue(1'b0, 4'd7, 8'h00, RD_WAIT + 1, 1'b1);

`ifdef SRAM_SEQ_WR_VERIFY_EN
        corrupt = 1'b1;
        issue(1'b1, 4'd2, 8'hFF, 0, 1'b1);
        wait_ready();
        corrupt = 1'b0;
        chk("wr_err_set", wr_err, 1);
        issue(1'b1, 4'd3, 8'h11, 0, 1'b1);
        wait_ready();
        chk("wr_err_sticky", wr_err, 1);
        arst_n = 1'b0;
        #1 chk("wr_err_cleared", wr_err, 0);
        @(posedge clk); #1;
        arst_n = 1'b1;
`else
        chk("wr_err_tied", wr_err, 0);
`endif

        wait_ready();
        repeat (2) @(posedge clk);
        #1;
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("wen_count", wen_cnt, exp_wen);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
